// File: rtl/adder_tree_pkg.sv
// Shared types and helpers for the pipelined signed adder tree.
// Defaults match the original 8x8-bit, 3-level tree.
package adder_tree_pkg;

  localparam int N_IN_DEF      = 8;
  localparam int IN_W_DEF      = 8;
  localparam int ACC_GUARD_DEF = 8;

  typedef struct packed {
    logic valid;
    logic accum;
    logic last;
  } tag_t;

  function automatic int level_width(
    input int in_w,
    input int l
  );
    return in_w + l;
  endfunction

endpackage

// File: rtl/adder_tree_if.sv
// Stream interface: operand vector in, tree/frame sum out.
// master drives operands and out_ready; slave is the tree.
interface adder_tree_if
  import adder_tree_pkg::*;
#(
  parameter int N_IN      = N_IN_DEF,
  parameter int IN_W      = IN_W_DEF,
  parameter int ACC_GUARD = ACC_GUARD_DEF
);
  localparam int OUT_W =
    level_width(IN_W, $clog2(N_IN)) + ACC_GUARD;

  logic [N_IN*IN_W-1:0] in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic                 accum_en;
  logic [OUT_W-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, in_last,
    output accum_en, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last,
    input  accum_en, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/adder_tree_level.sv
// One tree level: N_PAIRS signed pair sums, registered with enable.
// Each sum grows by one bit so it can never overflow.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int N_PAIRS = 1,
  parameter int W       = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en_i,
  input  logic [2*N_PAIRS*W-1:0]   d_i,
  input  tag_t                     tag_i,
  output logic [N_PAIRS*(W+1)-1:0] q_o,
  output tag_t                     tag_o
);
  localparam int OW = W + 1;

  logic [N_PAIRS*OW-1:0] q_d;
  logic [N_PAIRS*OW-1:0] q_q;
  tag_t                  tag_q;

  always_comb begin
    q_d = '0;
    for (int p = 0; p < N_PAIRS; p++) begin
      q_d[p*OW +: OW] =
        {d_i[(2*p+1)*W-1], d_i[2*p*W +: W]} +
        {d_i[(2*p+2)*W-1], d_i[(2*p+1)*W +: W]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_q   <= '0;
      tag_q <= '0;
    end else if (en_i) begin
      q_q   <= q_d;
      tag_q <= tag_i;
    end
  end

  assign q_o   = q_q;
  assign tag_o = tag_q;

endmodule

// File: rtl/adder_tree_pipelined_param.sv
// Pipelined signed adder tree, one register per level, with
// optional per-frame accumulation folded into the output stage.
module adder_tree_pipelined_param
  import adder_tree_pkg::*;
#(
  parameter int N_IN      = N_IN_DEF,
  parameter int IN_W      = IN_W_DEF,
  parameter int ACC_GUARD = ACC_GUARD_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  adder_tree_if.slave bus
);
  localparam int LVL   = $clog2(N_IN);
  localparam int SUM_W = level_width(IN_W, LVL);
  localparam int OUT_W = SUM_W + ACC_GUARD;

  logic stall;
  logic out_valid;
  tag_t tag0;

  assign tag0.valid = bus.in_valid;
  assign tag0.accum = bus.accum_en;
  assign tag0.last  = bus.in_last & bus.accum_en;

  for (genvar l = 1; l <= LVL; l++) begin : g_lvl
    localparam int W  = level_width(IN_W, l - 1);
    localparam int NP = N_IN >> l;

    logic [2*NP*W-1:0]   d;
    logic [NP*(W+1)-1:0] q;
    tag_t                ti;
    tag_t                to;

    if (l == 1) begin : g_first
      assign d  = bus.in_data;
      assign ti = tag0;
    end else begin : g_next
      assign d  = g_lvl[l-1].q;
      assign ti = g_lvl[l-1].to;
    end

    adder_tree_level #(
      .N_PAIRS (NP),
      .W       (W)
    ) u_lvl (
      .clk   (clk),
      .rstn  (rstn),
      .en_i  (~stall),
      .d_i   (d),
      .tag_i (ti),
      .q_o   (q),
      .tag_o (to)
    );
  end

  logic [SUM_W-1:0] tsum;
  logic [OUT_W-1:0] tsum_x;
  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] acc_d;
  tag_t             ft;

  assign tsum   = g_lvl[LVL].q;
  assign ft     = g_lvl[LVL].to;
  assign tsum_x = {{ACC_GUARD{tsum[SUM_W-1]}}, tsum};

  // Non-last frame members are absorbed here and never show as beats.
  assign out_valid = ft.valid & (~ft.accum | ft.last);
  assign stall     = out_valid & ~bus.out_ready;

  always_comb begin
    acc_d = acc_q;
    if (!stall && ft.valid && ft.accum) begin
      acc_d = ft.last ? '0 : acc_q + tsum_x;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = ft.accum ? acc_q + tsum_x
                                  : tsum_x;

endmodule
